// File: rtl/vga_color_fade.sv
// Pixel colour stage: holds on four keyframe colours and fades linearly between them at frame rate.
// Optional macro VGA_FADE_PINGPONG_EN: keyframes bounce 0,1,2,3,2,1,0... instead of wrapping 3 -> 0.
//
// state | meaning
// HOLD  | showing KEY[key_idx]; counting HOLD_FRAMES frames
// FADE  | interpolating KEY[key_idx] -> KEY[next] over 2**FADE_LOG2 frames
module vga_color_fade #(
  parameter logic [23:0] KEY0        = 24'h37C897,
  parameter logic [23:0] KEY1        = 24'hFF8040,
  parameter logic [23:0] KEY2        = 24'h0040FF,
  parameter logic [23:0] KEY3        = 24'h000000,
  parameter int          HOLD_FRAMES = 60,
  parameter int          FADE_LOG2   = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       frame_end,
  input  logic       run,
  input  logic [9:0] hPix,
  input  logic [9:0] vPix,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [1:0] key_idx,
  output logic       fading
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int KW = FADE_LOG2 + 1;
  localparam int CW = (HW > KW) ? HW : KW;
  localparam int PW = 10 + FADE_LOG2;
  localparam logic [KW-1:0] FADE_DONE = {1'b1, {FADE_LOG2{1'b0}}};

  typedef enum logic {HOLD, FADE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [23:0]   cur;
  logic [1:0]    nxt;
  logic [KW-1:0] k;
  logic [23:0]   src;
  logic [23:0]   dst;
  logic [23:0]   mix;
  logic          blank;

  function automatic logic [23:0] key_color(input logic [1:0] i);
    case (i)
      2'd0:    return KEY0;
      2'd1:    return KEY1;
      2'd2:    return KEY2;
      default: return KEY3;
    endcase
  endfunction

  // Floor-shift of a signed product; the result always lands between s and d.
  function automatic logic [7:0] lerp(input logic [7:0] s, input logic [7:0] d,
                                      input logic [KW-1:0] kk);
    logic signed [8:0]    diff;
    logic signed [PW-1:0] prod;
    diff = $signed({1'b0, d}) - $signed({1'b0, s});
    prod = PW'(diff) * PW'($signed({1'b0, kk}));
    return s + 8'(prod >>> FADE_LOG2);
  endfunction

`ifdef VGA_FADE_PINGPONG_EN
  logic dir;
  assign nxt = dir ? key_idx - 2'd1 : key_idx + 2'd1;
`else
  assign nxt = key_idx + 2'd1;
`endif

  assign k     = KW'(cnt + CW'(1));
  assign src   = key_color(key_idx);
  assign dst   = key_color(nxt);
  assign mix   = {lerp(src[23:16], dst[23:16], k),
                  lerp(src[15:8],  dst[15:8],  k),
                  lerp(src[7:0],   dst[7:0],   k)};
  assign blank = (hPix == 10'h3FF) || (vPix == 10'h3FF);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= HOLD;
      cnt     <= '0;
      cur     <= KEY0;
      key_idx <= 2'd0;
      fading  <= 1'b0;
`ifdef VGA_FADE_PINGPONG_EN
      dir     <= 1'b0;
`endif
    end else if (frame_end && run) begin
      case (state)
        HOLD: begin
          cur <= src;
          if (cnt == CW'(HOLD_FRAMES - 1)) begin
            state  <= FADE;
            cnt    <= '0;
            fading <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FADE: begin
          if (k == FADE_DONE) begin
            cur     <= dst;
            key_idx <= nxt;
            state   <= HOLD;
            cnt     <= '0;
            fading  <= 1'b0;
`ifdef VGA_FADE_PINGPONG_EN
            if (nxt == 2'd3)      dir <= 1'b1;
            else if (nxt == 2'd0) dir <= 1'b0;
`endif
          end else begin
            cur <= mix;
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

  // cur updates on the same edge, so a frame_end pixel still shows the old colour.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      red   <= 8'd0;
      green <= 8'd0;
      blue  <= 8'd0;
    end else if (blank) begin
      red   <= 8'd0;
      green <= 8'd0;
      blue  <= 8'd0;
    end else begin
      red   <= cur[23:16];
      green <= cur[15:8];
      blue  <= cur[7:0];
    end
  end

endmodule

// File: tb/tb_vga_color_fade.sv
// Bench for vga_color_fade: directed fade/pause/reset cases plus random frame and pixel traffic
// checked against a frame-count reference model.
module tb_vga_color_fade;

  localparam logic [23:0] K0 = 24'h000000;
  localparam logic [23:0] K1 = 24'hFF8040;
  localparam logic [23:0] K2 = 24'h000000;
  localparam logic [23:0] K3 = 24'h37C897;
  localparam int HOLD = 2;
  localparam int FL   = 2;
  localparam int NF   = 4;
  localparam int PER  = HOLD + NF;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       n_rst;
  logic       frame_end;
  logic       run;
  logic [9:0] hPix;
  logic [9:0] vPix;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic [1:0] key_idx;
  logic       fading;

  int total = 0;
  int bad = 0;
  int n = 0;
  int last_key = 0;
  int pdir = 0;

  vga_color_fade #(
    .KEY0(K0), .KEY1(K1), .KEY2(K2), .KEY3(K3),
    .HOLD_FRAMES(HOLD), .FADE_LOG2(FL)
  ) dut (
    .clk(clk), .n_rst(n_rst), .frame_end(frame_end), .run(run),
    .hPix(hPix), .vPix(vPix), .red(red), .green(green), .blue(blue),
    .key_idx(key_idx), .fading(fading)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] key_col(input int i);
    case (i)
      0:       return K0;
      1:       return K1;
      2:       return K2;
      default: return K3;
    endcase
  endfunction

  // Key shown during the s-th hold/fade segment since reset.
  function automatic int seq_key(input int s);
`ifdef VGA_FADE_PINGPONG_EN
    int pp[6] = '{0, 1, 2, 3, 2, 1};
    return pp[s % 6];
`else
    return s % 4;
`endif
  endfunction

  function automatic logic [7:0] interp(input int s, input int d, input int k);
    int v;
    int q;
    v = (d - s) * k;
    if (v >= 0) q = v / NF;
    else        q = -((-v + NF - 1) / NF);
    return 8'(s + q);
  endfunction

  function automatic logic [23:0] model_cur(input int frames);
    int r;
    int j;
    logic [23:0] a;
    logic [23:0] b;
    r = frames % PER;
    a = key_col(seq_key(frames / PER));
    b = key_col(seq_key(frames / PER + 1));
    j = r - HOLD;
    if (j <= 0) return a;
    return {interp(int'(a[23:16]), int'(b[23:16]), j),
            interp(int'(a[15:8]),  int'(b[15:8]),  j),
            interp(int'(a[7:0]),   int'(b[7:0]),   j)};
  endfunction

  function automatic int exp_next_key(input int prev);
`ifdef VGA_FADE_PINGPONG_EN
    if (prev == 3)      pdir = 1;
    else if (prev == 0) pdir = 0;
    return (pdir == 1) ? prev - 1 : prev + 1;
`else
    return (prev + 1) % 4;
`endif
  endfunction

  task automatic step(input logic fe, input logic rn, input logic [9:0] h, input logic [9:0] v);
    logic [23:0] exp_rgb;
    frame_end = fe;
    run = rn;
    hPix = h;
    vPix = v;
    exp_rgb = (h == 10'h3FF || v == 10'h3FF) ? 24'h0 : model_cur(n);
    @(posedge clk);
    #1;
    if (fe && rn) n++;
    chk("rgb", 32'({red, green, blue}), 32'(exp_rgb));
    chk("key_idx", 32'(key_idx), 32'(seq_key(n / PER)));
    chk("fading", 32'(fading), 32'((n % PER) >= HOLD));
    if (int'(key_idx) != last_key) begin
      chk("key_seq", 32'(key_idx), 32'(exp_next_key(last_key)));
      last_key = int'(key_idx);
    end
  endtask

  task automatic frame_look;
    step(1'b1, 1'b1, 10'd5, 10'd5);
    step(1'b0, 1'b1, 10'd5, 10'd5);
  endtask

  initial begin
    n_rst = 1'b0;
    frame_end = 1'b0;
    run = 1'b0;
    hPix = 10'd5;
    vPix = 10'd5;
    #20;
    chk("rst_rgb", 32'({red, green, blue}), 32'h0);
    chk("rst_key", 32'(key_idx), 32'd0);
    chk("rst_fading", 32'(fading), 32'd0);
    n_rst = 1'b1;
    #3;
    clk_en = 1'b1;

    step(1'b0, 1'b1, 10'd5, 10'd5);
    chk("first_pix", 32'({red, green, blue}), 32'(K0));
    step(1'b0, 1'b1, 10'h3FF, 10'd10);
    chk("blank_h", 32'({red, green, blue}), 32'h0);
    step(1'b0, 1'b1, 10'd100, 10'h3FF);
    chk("blank_v", 32'({red, green, blue}), 32'h0);
    step(1'b0, 1'b1, 10'd5, 10'd5);

    frame_look;
    frame_look;
    chk("fade_start", 32'(fading), 32'd1);
    frame_look;
    chk("up_k1", 32'({red, green, blue}), 32'h3F2010);
    frame_look;
    chk("up_k2", 32'({red, green, blue}), 32'h7F4020);
    frame_look;
    chk("up_k3", 32'({red, green, blue}), 32'hBF6030);
    frame_look;
    chk("up_done", 32'({red, green, blue}), 32'hFF8040);
    chk("up_key", 32'(key_idx), 32'd1);
    chk("up_fading", 32'(fading), 32'd0);

    frame_look;
    frame_look;
    frame_look;
    chk("down_k1", 32'({red, green, blue}), 32'hBF6030);
    frame_look;
    chk("down_k2", 32'({red, green, blue}), 32'h7F4020);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 10'd5, 10'd5);
      chk("pause_hold", 32'({red, green, blue}), 32'h7F4020);
    end
    frame_look;
    chk("resume_k3", 32'({red, green, blue}), 32'h3F2010);
    frame_look;
    chk("down_done", 32'({red, green, blue}), 32'h000000);
    chk("down_key", 32'(key_idx), 32'd2);

    for (int i = 0; i < 400; i++) begin
      logic fe;
      logic rn;
      logic [9:0] h;
      logic [9:0] v;
      fe = ($urandom_range(0, 2) == 0);
      rn = ($urandom_range(0, 3) != 0);
      h = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 639));
      v = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 479));
      step(fe, rn, h, v);
    end

    for (int i = 0; i < 20 && !((n % PER) > HOLD); i++) frame_look;
    chk("reach_mid_fade", 32'((n % PER) > HOLD), 32'd1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_rgb", 32'({red, green, blue}), 32'h0);
    chk("arst_key", 32'(key_idx), 32'd0);
    chk("arst_fading", 32'(fading), 32'd0);
    n = 0;
    last_key = 0;
    pdir = 0;
    #1;
    n_rst = 1'b1;
    step(1'b0, 1'b1, 10'd5, 10'd5);
    chk("arst_pix", 32'({red, green, blue}), 32'(K0));
    for (int i = 0; i < 30; i++) frame_look;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_color_fade.md
Name: vga_color_fade

Overview:
Pixel colour stage between vga_timing and the VGA DAC pins. It consumes hPix/vPix and a per-frame strobe, and drives 8-bit R/G/B. A frame-rate FSM holds on each of four keyframe colours, then linearly fades to the next one. The colour register updates only at frame end, so there is no tearing mid-frame.

Parameters:
KEY0, 24'h37C897, keyframe 0 colour {R,G,B}
KEY1, 24'hFF8040, keyframe 1 colour
KEY2, 24'h0040FF, keyframe 2 colour
KEY3, 24'h000000, keyframe 3 colour
HOLD_FRAMES, 60, frames to hold each keyframe; must be >= 1
FADE_LOG2, 6, fade length is 2**FADE_LOG2 frames; legal range 1..8

Ports:
clk  input  1  system clock (CLOCK_50 domain)
n_rst  input  1  asynchronous active-low reset
frame_end  input  1  one-clk strobe, once per frame, asserted during vertical blanking
run  input  1  1 = animation advances on frame_end; 0 = freeze
hPix  input  10  current pixel column from vga_timing; 10'h3FF = blanking
vPix  input  10  current pixel row from vga_timing; 10'h3FF = blanking
red  output  8  pixel red
green  output  8  pixel green
blue  output  8  pixel blue
key_idx  output  2  index of the current source keyframe
fading  output  1  1 while in FADE state

Behaviour:
- Reset (async, n_rst=0) sets:
  - red/green/blue = 0
  - key_idx = 0, fading = 0, state = HOLD, frame counter cnt = 0
  - internal colour cur = KEY0
- State and colour registers change only on clk edges where frame_end=1 and run=1. Otherwise they hold.
- HOLD state:
  - if cnt == HOLD_FRAMES-1: go to FADE, cnt <= 0
  - else cnt <= cnt+1
  - cur stays at KEY[key_idx]
- FADE state:
  - k = cnt+1
  - per channel: cur_c <= src_c + ((dst_c - src_c) * k) >>> FADE_LOG2
  - src = KEY[key_idx], dst = KEY[next]
- Interpolation arithmetic:
  - difference is signed 9-bit; product is signed (10+FADE_LOG2)-bit
  - shift is arithmetic (floor)
  - result is always within 0..255; truncate to 8 bits
- Fade completion, when k == 2**FADE_LOG2:
  - cur <= dst exactly
  - key_idx <= next, state HOLD, cnt <= 0
- next = key_idx+1 mod 4, i.e. wraps 3 -> 0 (see Optional Feature).
- fading = (state == FADE), registered.
- Pixel path, every clk, registered, latency 1 clk from hPix/vPix:
  - if hPix==10'h3FF or vPix==10'h3FF: {red,green,blue} <= 0
  - else {red,green,blue} <= cur
- Simultaneous frame_end with a visible pixel: the pixel output on that edge uses the old cur; the new cur applies from the next edge.
- run deasserted mid-fade: cnt and cur freeze; the fade resumes from the same k when run returns.
- Reset mid-fade: everything returns to the reset values immediately, without waiting for clk.

Optional Feature:
Macro VGA_FADE_PINGPONG_EN.
- Defined:
  - a direction register dir is added (reset 0 = up)
  - next = key_idx+1 when dir=0, key_idx-1 when dir=1
  - on arriving at key 3, dir <= 1; on arriving at key 0, dir <= 0
  - sequence is 0,1,2,3,2,1,0,1...
- Not defined: no dir register; sequence wraps 0,1,2,3,0...

Test Plan:
1. Reset:
   - stimulus: n_rst=0 with clk stopped
   - response: rgb=000000, key_idx=0, fading=0
   - then: after release, first visible pixel gives rgb=KEY0 one clk later
2. Blanking:
   - stimulus: hPix=3FF with vPix=10; then hPix=100 with vPix=3FF
   - response: rgb=0 for both; hPix=5, vPix=5 gives cur
3. Fade up, KEY0=000000, KEY1=FF8040, HOLD_FRAMES=2, FADE_LOG2=2:
   - frame_end 2 → fading=1
   - frame_ends 3, 4, 5 → rgb=3F2010, 7F4020, BF6030
   - frame_end 6 → FF8040, key_idx=1, fading=0
4. Fade down, KEY1=FF8040, KEY2=000000:
   - first fade step gives BF6030 (floor of negative difference)
   - final step gives 000000 exactly
5. Pause:
   - stimulus: run=0 for 10 frame_ends mid-fade at k=2
   - response: rgb stays at k=2; next run=1 frame_end gives k=3
6. Wrap or ping-pong:
   - stimulus: drive a full cycle of frame_ends
   - response without the macro: key_idx goes 3 → 0
   - response with VGA_FADE_PINGPONG_EN: key_idx goes 3 → 2 → 1 → 0 → 1
